pc_unit: RTL
============

# pc_unit

Program-counter stage of the single-cycle core. Holds the architectural PC, drives it to instruction memory and to the PC adder, and on each accepted fetch selects the next PC from the adder's sum, a branch target, a jump target, the exception vector or the saved EPC. Adds a fetch handshake, an exception/return path and a halt state, so the core can stall on slow instruction memory and park after a halt instruction.

## Interface
Parameters:
- RESET_VEC, 32'h0000_0000, PC value after reset
- EXC_VEC, 32'h0000_0080, exception entry address

Ports:
- i_clk  in  1  core clock, rising edge
- i_rst  in  1  reset; one clock; reset is synchronous and active-high
- i_pc4  in  32  PC+4 from the PC adder (sum of o_pc and 4, no carry-out)
- i_branch_taken  in  1  conditional branch resolved taken for the instruction at o_pc
- i_branch_target  in  32  branch target address
- i_jump  in  1  unconditional jump (J/JAL/JR) for the instruction at o_pc
- i_jump_target  in  32  jump target address
- i_eret  in  1  return-from-exception instruction at o_pc
- i_halt  in  1  halt instruction at o_pc
- i_exc  in  1  exception/interrupt request, level, unqualified
- i_imem_ready  in  1  instruction memory accepts the fetch at o_pc this cycle
- o_pc  out  32  current PC, to instruction memory and PC adder
- o_pc_valid  out  1  o_pc is a fetch request
- o_epc  out  32  saved exception PC
- o_state  out  2  FSM state code (debug)
- o_misaligned  out  1  one-cycle pulse: a redirect target had bits[1:0] != 0

## Operation
- accept = o_pc_valid & i_imem_ready. i_branch_taken, i_jump, i_eret, i_halt are ignored unless accept.
- States (o_state code): BOOT=0, RUN=1, WAIT=2, HALTED=3.
- BOOT: entered on reset; o_pc_valid=0; unconditionally -> RUN next cycle (i_exc ignored in BOOT).
- RUN: o_pc_valid=1. If !i_imem_ready -> WAIT, PC held. If accept, next PC chosen by priority:
  1. i_exc: PC<=EXC_VEC, EPC<=o_pc (instruction at o_pc is not retired).
  2. i_eret: PC<=o_epc.
  3. i_jump: PC<=i_jump_target.
  4. i_branch_taken: PC<=i_branch_target.
  5. i_halt: PC<=i_pc4, -> HALTED.
  6. else PC<=i_pc4.
- WAIT: o_pc_valid=1, PC held; i_imem_ready=1 behaves exactly as RUN accept, state -> RUN (HALTED if halt wins).
- i_exc in RUN or WAIT without accept: taken anyway; PC<=EXC_VEC, EPC<=o_pc, -> RUN.
- HALTED: o_pc_valid=0, PC held; only i_exc leaves: PC<=EXC_VEC, EPC<=o_pc (already PC+4 of halt), -> RUN.
- Misalignment: if selected jump/branch/eret target has bits[1:0]!=0, the redirect is replaced by an exception: PC<=EXC_VEC, EPC<=o_pc, o_misaligned=1 for that cycle.
- Arithmetic: none internal; i_pc4 wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000) and is used as given.

## Timing
- All state updates on rising i_clk; outputs registered except o_pc_valid, which decodes o_state.
- Reset (any state, mid-stall included): o_pc=RESET_VEC, o_epc=0, o_state=BOOT, o_pc_valid=0, o_misaligned=0 on the next edge.
- Redirect latency: one cycle; target appears on o_pc the cycle after accept. No delay slot.
- Exception latency: one cycle from i_exc sampled high to o_pc=EXC_VEC.
- o_misaligned is high exactly in the cycle after the faulting accept, alongside o_pc=EXC_VEC.
- Simultaneous i_exc and i_eret: exception wins; EPC overwritten with o_pc.

## Structure
- Shared core package: state encoding constants (BOOT/RUN/WAIT/HALTED), default RESET_VEC/EXC_VEC, 32-bit address width constant.
- One sub-module natural: pc_next_sel, the combinational priority mux + alignment check; the FSM, PC and EPC registers stay in pc_unit. The PC adder stays external and is fed o_pc.

## Test plan
- Reset then i_imem_ready=1, no redirects: o_pc 0x0 (valid=0 one cycle), then 0x0, 0x4, 0x8 on successive cycles, o_state BOOT->RUN.
- PC 0x10, i_imem_ready=0 for 3 cycles then 1 with i_branch_taken=1, target 0x40: o_pc holds 0x10 in WAIT, then 0x40.
- At PC 0x20, i_jump=1 target 0x100 and i_branch_taken=1 target 0x200 together: o_pc=0x100.
- At PC 0x30 i_exc=1 with i_imem_ready=0: o_pc=0x80, o_epc=0x30; later i_eret at accept: o_pc=0x30.
- i_jump target 0x102 at PC 0x50: o_pc=0x80, o_epc=0x50, o_misaligned=1 one cycle.
- i_halt at PC 0x60: o_pc=0x64, o_pc_valid=0 and held 10 cycles; i_exc -> o_pc=0x80, o_epc=0x64. Also i_pc4=0 at PC 0xFFFF_FFFC -> o_pc=0x0; i_rst mid-WAIT -> o_pc=RESET_VEC, BOOT.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// Shared definitions for the program-counter stage: state codes,
// default vectors and address width.
package pc_unit_pkg;

  localparam int unsigned ADDR_W = 32;

  localparam logic [ADDR_W-1:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] DEF_EXC_VEC   = 32'h0000_0080;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_WAIT   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux for an accepted fetch (or a pending exception),
// including the redirect-target alignment check.
module pc_next_sel
  import pc_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] EXC_VEC = DEF_EXC_VEC
) (
  input  logic              exc,
  input  logic              eret,
  input  logic              jump,
  input  logic              branch_taken,
  input  logic              halt,
  input  logic [ADDR_W-1:0] pc4,
  input  logic [ADDR_W-1:0] epc,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] next_pc,
  output logic              take_exc,
  output logic              misaligned,
  output logic              go_halt
);

  logic              redirect;
  logic [ADDR_W-1:0] target;

  // Priority select: exception, eret, jump, branch, halt, sequential.
  // A misaligned redirect target turns into an exception entry.
  always_comb begin
    next_pc    = pc4;
    take_exc   = 1'b0;
    misaligned = 1'b0;
    go_halt    = 1'b0;
    redirect   = 1'b0;
    target     = '0;
    if (exc) begin
      next_pc  = EXC_VEC;
      take_exc = 1'b1;
    end else begin
      if (eret) begin
        redirect = 1'b1;
        target   = epc;
      end else if (jump) begin
        redirect = 1'b1;
        target   = jump_target;
      end else if (branch_taken) begin
        redirect = 1'b1;
        target   = branch_target;
      end else if (halt) begin
        go_halt = 1'b1;
      end
      if (redirect) begin
        if (target[1:0] != 2'b00) begin
          next_pc    = EXC_VEC;
          take_exc   = 1'b1;
          misaligned = 1'b1;
        end else begin
          next_pc = target;
        end
      end
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: fetch handshake FSM, PC and EPC registers.
//
// state  | meaning
// BOOT   | first cycle after reset, no fetch issued
// RUN    | fetch requested at o_pc
// WAIT   | fetch requested, instruction memory stalled, PC held
// HALTED | parked after halt, no fetch, only an exception leaves
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [ADDR_W-1:0] EXC_VEC   = DEF_EXC_VEC
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_pc4,
  input  logic              i_branch_taken,
  input  logic [ADDR_W-1:0] i_branch_target,
  input  logic              i_jump,
  input  logic [ADDR_W-1:0] i_jump_target,
  input  logic              i_eret,
  input  logic              i_halt,
  input  logic              i_exc,
  input  logic              i_imem_ready,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_pc_valid,
  output logic [ADDR_W-1:0] o_epc,
  output logic [1:0]        o_state,
  output logic              o_misaligned
);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc_q, pc_nx, epc_q, epc_nx;
  logic              mis_q, mis_nx;
  logic [ADDR_W-1:0] sel_pc;
  logic              sel_exc, sel_mis, sel_halt;

  pc_next_sel #(.EXC_VEC(EXC_VEC)) u_sel (
    .exc           (i_exc),
    .eret          (i_eret),
    .jump          (i_jump),
    .branch_taken  (i_branch_taken),
    .halt          (i_halt),
    .pc4           (i_pc4),
    .epc           (epc_q),
    .jump_target   (i_jump_target),
    .branch_target (i_branch_target),
    .next_pc       (sel_pc),
    .take_exc      (sel_exc),
    .misaligned    (sel_mis),
    .go_halt       (sel_halt)
  );

  // State, PC, EPC and misalignment-pulse registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_BOOT;
      pc_q  <= RESET_VEC;
      epc_q <= '0;
      mis_q <= 1'b0;
    end else begin
      state <= state_nx;
      pc_q  <= pc_nx;
      epc_q <= epc_nx;
      mis_q <= mis_nx;
    end
  end

  // Next state and register updates; an exception is taken in RUN/WAIT
  // even without a handshake, since it does not need the fetch.
  always_comb begin
    state_nx = state;
    pc_nx    = pc_q;
    epc_nx   = epc_q;
    mis_nx   = 1'b0;
    case (state)
      ST_BOOT: state_nx = ST_RUN;
      ST_RUN, ST_WAIT: begin
        if (i_exc || i_imem_ready) begin
          pc_nx    = sel_pc;
          mis_nx   = sel_mis;
          state_nx = sel_halt ? ST_HALTED : ST_RUN;
          if (sel_exc) epc_nx = pc_q;
        end else begin
          state_nx = ST_WAIT;
        end
      end
      ST_HALTED: begin
        if (i_exc) begin
          pc_nx    = EXC_VEC;
          epc_nx   = pc_q;
          state_nx = ST_RUN;
        end
      end
      default: state_nx = ST_BOOT;
    endcase
  end

  assign o_pc         = pc_q;
  assign o_epc        = epc_q;
  assign o_state      = state;
  assign o_misaligned = mis_q;
  assign o_pc_valid   = (state == ST_RUN) || (state == ST_WAIT);

endmodule
